render_mux_n: RTL and testbench

RENDER_MUX_N -- requirements
Module: render_mux_n

---
 rtl/render_mux_n.sv | 136 +++++++++++++
 tb/tb_render_mux_n.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/render_mux_n.sv
// Two-stage sprite compositor: picks the winning layer colour per pixel, then
// applies a frame-driven brightness fade and blanks pixels outside the display.
module render_mux_n #(
    parameter int NUM_LAYERS   = 3,
    parameter int RGB_W        = 12,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    input  logic                        video_on,
    input  logic                        frame_tick,
    input  logic [NUM_LAYERS-1:0]       layer_on,
    input  logic [NUM_LAYERS*RGB_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic [RGB_W-1:0]            bg_rgb,
    input  logic [1:0]                  game_state,
    output logic [RGB_W-1:0]            rgb,
    output logic                        video_on_o,
    output logic [9:0]                  x_o,
    output logic [9:0]                  y_o
);

    localparam int CH_W   = RGB_W / 3;
    localparam int WIN_P2 = (NUM_LAYERS > 1) ? 1 : 0;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_PLAY = 2'b01;
    localparam logic [1:0] ST_WIN1 = 2'b10;
    localparam logic [1:0] ST_WIN2 = 2'b11;

    localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

    logic [1:0]       r_state;
    logic [1:0]       r_lvl;
    logic [7:0]       r_blink_cnt;
    logic             r_blink_phase;

    logic [RGB_W-1:0] r_s1_rgb;
    logic             r_s1_vid;
    logic [9:0]       r_s1_x;
    logic [9:0]       r_s1_y;

    logic [RGB_W-1:0] r_rgb;
    logic             r_vid;
    logic [9:0]       r_x;
    logic [9:0]       r_y;

    logic [RGB_W-1:0] w_sel;
    logic [RGB_W-1:0] w_shaded;
    logic [1:0]       w_shift;

    // Descending scan so the lowest-index enabled hit overrides all others.
    always_comb begin
        w_sel = '0;
        case (game_state)
            ST_PLAY: begin
                w_sel = bg_rgb;
                for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
                    if (layer_on[i] && layer_en[i]) begin
                        w_sel = layer_rgb[i*RGB_W +: RGB_W];
                    end
                end
            end
            ST_WIN1: w_sel = r_blink_phase ? layer_rgb[0 +: RGB_W] : bg_rgb;
            ST_WIN2: w_sel = r_blink_phase ? layer_rgb[WIN_P2*RGB_W +: RGB_W] : bg_rgb;
            ST_IDLE: w_sel = '0;
            default: w_sel = '0;
        endcase
    end

    always_comb begin
        w_shaded = '0;
        w_shift  = 2'd3 - r_lvl;
        for (int c = 0; c < 3; c++) begin
            w_shaded[c*CH_W +: CH_W] = r_s1_rgb[c*CH_W +: CH_W] >> w_shift;
        end
    end

    // A game_state change always restarts the fade, even on a frame_tick.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_lvl         <= 2'd3;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else begin
            r_state <= game_state;
            if (game_state != r_state) begin
                r_lvl <= 2'd0;
            end else if (frame_tick && (r_lvl != 2'd3)) begin
                r_lvl <= r_lvl + 2'd1;
            end
            if (!game_state[1]) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b1;
            end else if (frame_tick) begin
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt   <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_s1_rgb <= '0;
            r_s1_vid <= 1'b0;
            r_s1_x   <= '0;
            r_s1_y   <= '0;
            r_rgb    <= '0;
            r_vid    <= 1'b0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            r_s1_rgb <= w_sel;
            r_s1_vid <= video_on;
            r_s1_x   <= x;
            r_s1_y   <= y;
            r_rgb    <= r_s1_vid ? w_shaded : '0;
            r_vid    <= r_s1_vid;
            r_x      <= r_s1_x;
            r_y      <= r_s1_y;
        end
    end

    assign rgb        = r_rgb;
    assign video_on_o = r_vid;
    assign x_o        = r_x;
    assign y_o        = r_y;

endmodule

// File: tb/tb_render_mux_n.sv
// Scoreboard bench for render_mux_n: an independent model predicts every output
// cycle, plus directed colour checks for fade, blink, priority and reset.
module tb_render_mux_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  x, y;
    logic        video_on;
    logic        frame_tick;
    logic [2:0]  layer_on;
    logic [35:0] layer_rgb;
    logic [2:0]  layer_en;
    logic [11:0] bg_rgb;
    logic [1:0]  game_state;
    logic [11:0] rgb;
    logic        video_on_o;
    logic [9:0]  x_o, y_o;

    int nAssert = 0;
    int nFail   = 0;

    typedef struct {
        logic [11:0] rgb;
        logic        vid;
        logic [9:0]  x;
        logic [9:0]  y;
    } item_t;

    item_t sb[$];

    logic [1:0] mState;
    int         mLvl;
    int         mCnt;
    logic       mPhase;

    render_mux_n #(.NUM_LAYERS(3), .RGB_W(12), .BLINK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .video_on(video_on),
        .frame_tick(frame_tick), .layer_on(layer_on), .layer_rgb(layer_rgb),
        .layer_en(layer_en), .bg_rgb(bg_rgb), .game_state(game_state),
        .rgb(rgb), .video_on_o(video_on_o), .x_o(x_o), .y_o(y_o)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] shade(logic [11:0] c, int lvl);
        logic [3:0] r, g, b;
        int s;
        s = 3 - lvl;
        r = c[11:8] >> s;
        g = c[7:4] >> s;
        b = c[3:0] >> s;
        return {r, g, b};
    endfunction

    function automatic logic [11:0] modelSelect();
        logic [11:0] l0, l1, l2;
        l0 = layer_rgb[11:0];
        l1 = layer_rgb[23:12];
        l2 = layer_rgb[35:24];
        case (game_state)
            2'b00: return 12'h000;
            2'b01: begin
                if (layer_on[0] && layer_en[0]) return l0;
                else if (layer_on[1] && layer_en[1]) return l1;
                else if (layer_on[2] && layer_en[2]) return l2;
                else return bg_rgb;
            end
            2'b10: return mPhase ? l0 : bg_rgb;
            default: return mPhase ? l1 : bg_rgb;
        endcase
    endfunction

    // One clock: predict this edge's output from the queued stage-1 item,
    // queue the new stage-1 item, advance the model, then compare.
    task automatic applyStimulus();
        item_t cur, nxt, zero;
        logic [11:0] expRgb;
        zero = '{rgb: 12'h0, vid: 1'b0, x: 10'h0, y: 10'h0};
        expRgb = 12'h0;
        cur = zero;
        if (!reset) begin
            sb.delete();
            sb.push_back(zero);
            mState = 2'b00;
            mLvl   = 3;
            mCnt   = 0;
            mPhase = 1'b1;
        end else begin
            if (sb.size() > 0) cur = sb.pop_front();
            expRgb = cur.vid ? shade(cur.rgb, mLvl) : 12'h000;
            nxt = '{rgb: modelSelect(), vid: video_on, x: x, y: y};
            sb.push_back(nxt);
            if (game_state != mState) mLvl = 0;
            else if (frame_tick && mLvl < 3) mLvl = mLvl + 1;
            mState = game_state;
            if (!game_state[1]) begin
                mCnt   = 0;
                mPhase = 1'b1;
            end else if (frame_tick) begin
                if (mCnt == 1) begin
                    mCnt   = 0;
                    mPhase = ~mPhase;
                end else begin
                    mCnt = mCnt + 1;
                end
            end
        end
        @(posedge clk);
        #1;
        nAssert++;
        assert ({rgb, video_on_o, x_o, y_o} === {expRgb, cur.vid, cur.x, cur.y})
        else begin
            nFail++;
            $error("[TB] FAIL scoreboard: got rgb=%h vid=%b x=%0d y=%0d, expected rgb=%h vid=%b x=%0d y=%0d",
                   rgb, video_on_o, x_o, y_o, expRgb, cur.vid, cur.x, cur.y);
        end
    endtask

    task automatic checkOutput(string tag, logic [11:0] act, logic [11:0] exp);
        nAssert++;
        assert (act === exp)
        else begin
            nFail++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        applyStimulus();
        frame_tick = 1'b0;
        repeat (3) applyStimulus();
    endtask

    initial begin
        logic [11:0] blinkExp [5];
        blinkExp = '{12'h000, 12'hF00, 12'hF00, 12'h000, 12'h000};

        reset = 1'b0; x = 10'd17; y = 10'd33; video_on = 1'b1; frame_tick = 1'b0;
        layer_on = 3'b001; layer_en = 3'b111; layer_rgb = {12'h00F, 12'h0F0, 12'hFFF};
        bg_rgb = 12'h123; game_state = 2'b00;
        repeat (3) applyStimulus();
        checkOutput("reset_rgb", rgb, 12'h000);
        checkOutput("reset_vid", {11'h0, video_on_o}, 12'h000);
        checkOutput("reset_x", {2'b0, x_o}, 12'h000);

        reset = 1'b1;
        repeat (2) applyStimulus();
        checkOutput("idle_rgb", rgb, 12'h000);
        checkOutput("idle_vid", {11'h0, video_on_o}, 12'h001);

        game_state = 2'b01;
        repeat (2) applyStimulus();
        checkOutput("fade_lvl0", rgb, 12'h111);
        frame();
        checkOutput("fade_lvl1", rgb, 12'h333);
        frame();
        checkOutput("fade_lvl2", rgb, 12'h777);
        frame();
        checkOutput("fade_lvl3", rgb, 12'hFFF);
        frame();
        checkOutput("fade_hold", rgb, 12'hFFF);

        layer_on = 3'b011; layer_rgb = {12'h00F, 12'h0F0, 12'hF00};
        repeat (2) applyStimulus();
        checkOutput("prio_l0", rgb, 12'hF00);
        layer_en = 3'b110;
        repeat (2) applyStimulus();
        checkOutput("prio_en", rgb, 12'h0F0);
        layer_en = 3'b000;
        repeat (2) applyStimulus();
        checkOutput("all_dis_bg", rgb, 12'h123);
        layer_en = 3'b111; layer_on = 3'b000; video_on = 1'b0;
        repeat (2) applyStimulus();
        checkOutput("blank_rgb", rgb, 12'h000);
        checkOutput("blank_vid", {11'h0, video_on_o}, 12'h000);

        video_on = 1'b1; game_state = 2'b10; bg_rgb = 12'h000;
        repeat (2) applyStimulus();
        repeat (2) frame();
        for (int f = 0; f < 5; f++) begin
            frame();
            checkOutput($sformatf("blink_f%0d", f + 3), rgb, blinkExp[f]);
        end
        game_state = 2'b01;
        repeat (2) applyStimulus();
        game_state = 2'b10;
        repeat (2) applyStimulus();
        checkOutput("blink_restore", rgb, 12'h100);

        game_state = 2'b01; layer_on = 3'b001; frame_tick = 1'b1;
        applyStimulus();
        frame_tick = 1'b0;
        applyStimulus();
        checkOutput("change_wins", rgb, 12'h100);
        frame();
        checkOutput("mid_fade", rgb, 12'h300);
        reset = 1'b0;
        applyStimulus();
        checkOutput("reset_mid", rgb, 12'h000);
        reset = 1'b1; game_state = 2'b00;
        repeat (2) applyStimulus();
        checkOutput("post_rst_idle", rgb, 12'h000);
        game_state = 2'b01;
        repeat (2) applyStimulus();
        checkOutput("post_rst_fade", rgb, 12'h100);

        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 299) != 0);
            x          = 10'($urandom);
            y          = 10'($urandom);
            video_on   = ($urandom_range(0, 7) != 0);
            frame_tick = ($urandom_range(0, 7) == 0);
            layer_on   = 3'($urandom);
            layer_en   = 3'($urandom);
            layer_rgb  = 36'({$urandom(), $urandom()});
            bg_rgb     = 12'($urandom);
            if ($urandom_range(0, 49) == 0) game_state = 2'($urandom);
            applyStimulus();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
